// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the
// round-robin 4:1 mux arbiter.
package rr_mux4_arbiter_pkg;

  localparam int NUM_REQ      = 4;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Request/grant and data bundle between
// the requester side and the arbiter.
interface rr_mux4_arbiter_if;
  import rr_mux4_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         sel;
  logic               busy;
  logic               data_out;

  modport master (
    output req,
    output data_in,
    input  grant,
    input  sel,
    input  busy,
    input  data_out
  );

  modport slave (
    input  req,
    input  data_in,
    output grant,
    output sel,
    output busy,
    output data_out
  );

endinterface

// File: rtl/MUX4in.sv
// Library 4:1 single-bit mux cell.
// s1/s0 select i0..i3.
module MUX4in (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic out
);

  always_comb begin
    unique case ({s1, s0})
      2'd0:    out = i0;
      2'd1:    out = i1;
      2'd2:    out = i2;
      default: out = i3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating priority picker: first request
// at or after ptr, optionally skipping one.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic       found,
  output logic [1:0] win
);

  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx] &&
          !(excl_en && idx == excl_idx)) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with hold limit that
// steers a shared MUX4in path to one owner.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_mux4_arbiter_if.slave bus
);

  state_e     state_q;
  logic [3:0] grant_q;
  logic [1:0] sel_q;
  logic       busy_q;
  logic [1:0] ptr_q;
  logic [CNT_W-1:0] hold_q;

  logic [1:0] ptr_d;
  logic [1:0] pick_ptr;
  logic       pick_excl;
  logic       found;
  logic [1:0] win;
  logic       owner_req;
  logic       hold_max;
  logic       mux_out;

  assign ptr_d     = sel_q + 2'd1;
  assign pick_excl = (state_q == ST_BUSY);
  // While busy, scan from the slot after the owner, skipping it.
  assign pick_ptr  = pick_excl ? ptr_d : ptr_q;
  assign owner_req = bus.req[sel_q];
  assign hold_max  = (hold_q == CNT_W'(MAX_HOLD));

  rr_pick4 u_pick (
    .req      (bus.req),
    .ptr      (pick_ptr),
    .excl_en  (pick_excl),
    .excl_idx (sel_q),
    .found    (found),
    .win      (win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_q <= ST_BUSY;
            grant_q <= 4'b0001 << win;
            sel_q   <= win;
            busy_q  <= 1'b1;
            hold_q  <= CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (!owner_req || (hold_max && found)) begin
            ptr_q <= ptr_d;
            if (found) begin
              grant_q <= 4'b0001 << win;
              sel_q   <= win;
              hold_q  <= CNT_W'(1);
            end else begin
              state_q <= ST_IDLE;
              grant_q <= 4'b0000;
              sel_q   <= 2'd0;
              busy_q  <= 1'b0;
              hold_q  <= '0;
            end
          end else if (!hold_max) begin
            hold_q <= hold_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  MUX4in u_mux (
    .i0  (bus.data_in[0]),
    .i1  (bus.data_in[1]),
    .i2  (bus.data_in[2]),
    .i3  (bus.data_in[3]),
    .s0  (sel_q[0]),
    .s1  (sel_q[1]),
    .out (mux_out)
  );

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = mux_out & busy_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Randomised and directed bench for the
// round-robin mux arbiter vs a rotation model.
module tb_rr_mux4_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int m_own;
  int m_hold;
  int m_ptr;

  rr_mux4_arbiter_if bus ();

  rr_mux4_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  function automatic int scan(
    input logic [3:0] r,
    input int start,
    input int excl);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (start + i) % 4;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r,
                            input logic rn);
    int w;
    if (!rn) begin
      m_own  = -1;
      m_hold = 0;
      m_ptr  = 0;
    end else if (m_own < 0) begin
      w = scan(r, m_ptr, -1);
      if (w >= 0) begin
        m_own  = w;
        m_hold = 1;
      end
    end else if (!r[m_own]) begin
      m_ptr  = (m_own + 1) % 4;
      w      = scan(r, m_ptr, m_own);
      m_own  = w;
      m_hold = (w >= 0) ? 1 : 0;
    end else begin
      w = scan(r, (m_own + 1) % 4, m_own);
      if (m_hold == MAX_HOLD && w >= 0) begin
        m_ptr  = (m_own + 1) % 4;
        m_own  = w;
        m_hold = 1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
  endtask

  // Drive one cycle, check outputs against
  // the model, then advance the model at the edge.
  task automatic cyc(input logic [3:0] r,
                     input logic [3:0] d,
                     input logic rn);
    logic [3:0] eg;
    logic [1:0] es;
    logic       eb;
    logic       ed;
    @(negedge clk);
    bus.req     = r;
    bus.data_in = d;
    rst_n       = rn;
    #1;
    eb = (m_own >= 0);
    eg = eb ? (4'b0001 << m_own) : 4'b0000;
    es = eb ? 2'(m_own) : 2'd0;
    ed = eb ? d[es] : 1'b0;
    check("grant", 32'(bus.grant), 32'(eg));
    check("sel", 32'(bus.sel), 32'(es));
    check("busy", 32'(bus.busy), 32'(eb));
    check("dout", 32'(bus.data_out), 32'(ed));
    @(posedge clk);
    model_step(r, rn);
  endtask

  initial begin
    logic [3:0] r;
    logic       rn;
    checks      = 0;
    errors      = 0;
    bus.req     = 4'b1111;
    bus.data_in = 4'b0000;
    rst_n       = 1'b0;
    m_own       = -1;
    m_hold      = 0;
    m_ptr       = 0;
    @(posedge clk);

    cyc(4'b1111, 4'($urandom), 1'b0);
    cyc(4'b1111, 4'($urandom), 1'b0);
    #2;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_dout", 32'(bus.data_out), 32'h0);

    cyc(4'b1111, 4'($urandom), 1'b1);
    for (int j = 0; j < 20; j++) begin
      #2;
      check("rr_seq", 32'(bus.grant),
            32'(4'b0001 << ((j / 4) % 4)));
      cyc(4'b1111, 4'($urandom), 1'b1);
    end

    cyc(4'b0000, 4'hf, 1'b0);
    cyc(4'b0100, 4'($urandom), 1'b1);
    #2;
    check("single", 32'(bus.grant), 32'h4);
    for (int j = 0; j < 12; j++)
      cyc(4'b0100, 4'($urandom), 1'b1);
    #2;
    check("single_hold", 32'(bus.grant), 32'h4);

    cyc(4'b0000, 4'h0, 1'b0);
    cyc(4'b0010, 4'($urandom), 1'b1);
    cyc(4'b1010, 4'($urandom), 1'b1);
    cyc(4'b1000, 4'($urandom), 1'b1);
    #2;
    check("handover", 32'(bus.grant), 32'h8);
    check("no_bubble", 32'(bus.busy), 32'h1);
    cyc(4'b0000, 4'($urandom), 1'b1);
    #2;
    check("idle", 32'(bus.busy), 32'h0);

    cyc(4'b0000, 4'h0, 1'b0);
    cyc(4'b0001, 4'($urandom), 1'b1);
    cyc(4'b0011, 4'($urandom), 1'b1);
    cyc(4'b0010, 4'($urandom), 1'b1);
    #2;
    check("rel_rereq", 32'(bus.grant), 32'h2);
    for (int j = 0; j < 6; j++)
      cyc(4'b0011, 4'($urandom), 1'b1);

    cyc(4'b0000, 4'h0, 1'b0);
    cyc(4'b0100, 4'($urandom), 1'b1);
    cyc(4'b1111, 4'($urandom), 1'b0);
    #2;
    check("mid_rst", 32'(bus.grant), 32'h0);
    cyc(4'b1111, 4'($urandom), 1'b1);
    #2;
    check("post_rst", 32'(bus.grant), 32'h1);

    r = 4'($urandom);
    for (int j = 0; j < 500; j++) begin
      if ($urandom_range(0, 2) == 0)
        r = 4'($urandom);
      rn = ($urandom_range(0, 59) != 0);
      cyc(r, 4'($urandom), rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares a 4:1 single-bit mux path among four requesters.
- Samples four request lines and registers a one-hot grant plus a 2-bit select.
- The select drives the MUX4in cell: s1=sel[1], s0=sel[0].
- Enforces a maximum hold time so a continuously requesting owner cannot starve the others.

Parameters:
MAX_HOLD, 4, maximum consecutive granted cycles while another requester waits; legal range 1..7.
CNT_W, 3, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
req  input  4  request per requester; req[k] for requester k.
data_in  input  4  data bit per requester; data_in[k] is mux input ik.
grant  output  4  registered one-hot grant; all zero when idle.
sel  output  2  registered mux select (sel[1]=s1, sel[0]=s0).
busy  output  1  registered; 1 while any grant is active.
data_out  output  1  mux output when busy, else 0.

Behaviour:
- Reset: sampled only at the clock edge while rst_n=0. Sets state=IDLE, grant=4'b0000, sel=2'd0, busy=0, hold_cnt=0, ptr=2'd0.
- Reset mid-grant: the grant drops at that same edge. Requests are re-arbitrated from ptr=0 after rst_n returns to 1.
- data_out is combinational: busy ? data_in[sel] : 1'b0. Zero added latency from data_in.
- Winner function: the first index k with req[k]=1 and k not excluded, scanning ptr, ptr+1, ... modulo 4. Wraps 3->0.
- FSM states: IDLE, BUSY.
- IDLE, req==0: stay in IDLE; outputs unchanged.
- IDLE, any req: winner w computed from ptr. Next edge: grant=1<<w, sel=w, busy=1, hold_cnt=1, state=BUSY. Latency from request seen to grant is 1 cycle.
- BUSY, release (req[sel]=0): ptr<=sel+1 (mod 4). Arbitrate the remaining requests from sel+1, excluding the old owner.
  - If there is a winner, move the grant at the next edge with no idle bubble; hold_cnt=1.
  - Otherwise go to IDLE with grant=0 and busy=0.
- BUSY, preempt (req[sel]=1, hold_cnt==MAX_HOLD, another req set): ptr<=sel+1. The grant moves to the winner from sel+1, excluding the old owner; hold_cnt=1.
- BUSY, preempted owner: it keeps requesting and is re-served in its next rotation turn.
- BUSY, continue (req[sel]=1, not preempting): grant and sel hold. hold_cnt increments and saturates at MAX_HOLD.
- Sole requester: holds the grant indefinitely; hold_cnt stays saturated.
- Simultaneous release by the owner and new requests: the owner is excluded in that cycle. A re-asserted owner request competes normally from the following cycle.
- Invariants: grant is always one-hot or zero; grant[sel]=1 whenever busy=1; sel=0 whenever busy=0.
- Deassertion of a waiting (non-owner) request has no effect.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - NUM_REQ=4;
  - the default MAX_HOLD.
- Sub-module rr_pick4: combinational. Inputs req[3:0], ptr[1:0], excl_en, excl_idx[1:0]. Outputs found and win[1:0].
- The data path instantiates the existing MUX4in cell, with out gated by busy.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0000, sel=0, busy=0, data_out=0. First grant after release of reset = 0001.
- Single requester: req=4'b0100 from cycle 1 -> grant=0100 and sel=2 at cycle 2. Grant held for 10+ cycles; data_out follows data_in[2] in the same cycle.
- Full contention, MAX_HOLD=4, req=1111 held: grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles. Wrap 3->0 verified.
- Release handover: owner 1 drops req while req[3]=1 -> the next cycle grants 1000 with busy continuously 1 (no bubble). If nobody is waiting, busy=0 one cycle after the drop.
- Release plus re-request: owner 0 drops req and re-asserts 1 cycle later while req[1]=1 -> grant 0010. Requester 0 is regranted only after 1 releases or is preempted.
- Mid-operation reset: grant=0100 when rst_n pulses low for 1 cycle -> grant=0 at that edge. With req=1111 afterwards, the first grant is 0001.
